// File: rtl/key_report_pkg.sv
// Shared types and constants for the keyboard boot-report builder.
package key_report_pkg;

    localparam int KR_CODE_W = 8;

    typedef logic [KR_CODE_W-1:0] slot_t;

    localparam slot_t KEY_NONE         = 8'h00;
    localparam slot_t KEY_ROLLOVER     = 8'h01;
    localparam slot_t KEY_ENTER        = 8'h28;
    localparam slot_t KEY_RESERVED_MAX = 8'h03;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        APPLY
    } kr_state_t;

    // Usage codes 0x00..0x03 are "no key" / error codes and never enter the table.
    function automatic logic is_reserved(input slot_t code);
        return code <= KEY_RESERVED_MAX;
    endfunction

endpackage

// File: rtl/key_slot_table.sv
// Pressed-key slot storage: write-at-index, remove-and-compact, per-slot read.
// Occupied slots stay contiguous from slot 0; empty slots hold 0x00.
module key_slot_table
    import key_report_pkg::*;
#(
    parameter int NUM_SLOTS = 6,
    parameter int CODE_W    = 8,
    localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [CODE_W-1:0]           wr_code,
    input  logic                        rm_en,
    input  logic [IDX_W-1:0]            rm_idx,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [CODE_W-1:0]           rd_code,
    output logic [NUM_SLOTS*CODE_W-1:0] slots
);

    logic [CODE_W-1:0] slot_q [NUM_SLOTS];

    // Slot registers: clear beats remove, remove beats write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
        end else if (rm_en) begin
            // Drop slot rm_idx and shift everything above it down by one.
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                if (IDX_W'(i) >= rm_idx) slot_q[i] <= slot_q[i+1];
            end
            slot_q[NUM_SLOTS-1] <= CODE_W'(KEY_NONE);
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_idx == IDX_W'(i)) slot_q[i] <= wr_code;
            end
        end
    end

    // Single-slot read port used by the scan.
    always_comb begin
        rd_code = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_code = slot_q[i];
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_flat
        assign slots[g*CODE_W +: CODE_W] = slot_q[g];
    end

endmodule

// File: rtl/key_report_builder.sv
// Builds the 6-key boot-protocol report from serial make/break events.
// Optional build macro KEY_REPORT_BUILDER_STUCK_CLEAR_EN adds an idle
// auto-clear after STUCK_CYCLES cycles with keys held and no events.
module key_report_builder
    import key_report_pkg::*;
#(
    parameter int          NUM_SLOTS    = 6,
    parameter int          CODE_W       = 8,
    parameter int unsigned STUCK_CYCLES = 50_000_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic [CODE_W-1:0]           ev_code,
    input  logic                        ev_make,
    input  logic                        clear_all,
    output logic [NUM_SLOTS*CODE_W-1:0] keycode,
    output logic                        report_valid,
    output logic                        rollover
);

    localparam int               IDX_W    = $clog2(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
    localparam logic [3:0]       OVF_MAX  = 4'hF;

    kr_state_t                   state_q, state_d;
    logic [CODE_W-1:0]           code_q;
    logic                        make_q;
    logic [IDX_W-1:0]            scan_idx_q;
    logic                        match_found_q, free_found_q;
    logic [IDX_W-1:0]            match_idx_q, free_idx_q;
    logic [3:0]                  ovf_q, ovf_d;
    logic [CODE_W-1:0]           rd_code;
    logic [NUM_SLOTS*CODE_W-1:0] table_flat, pub, prev_pub_q;
    logic                        tbl_wr, tbl_rm, accept, clr_req, stuck_hit, table_empty;

    assign table_empty = (table_flat[CODE_W-1:0] == '0);
    assign clr_req     = clear_all | stuck_hit;
    assign ev_ready    = (state_q == IDLE) & ~clr_req;
    assign accept      = ev_valid & ev_ready;

    key_slot_table #(
        .NUM_SLOTS(NUM_SLOTS),
        .CODE_W   (CODE_W)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr_req),
        .wr_en  (tbl_wr),
        .wr_idx (free_idx_q),
        .wr_code(code_q),
        .rm_en  (tbl_rm),
        .rm_idx (match_idx_q),
        .rd_idx (scan_idx_q),
        .rd_code(rd_code),
        .slots  (table_flat)
    );

`ifdef KEY_REPORT_BUILDER_STUCK_CLEAR_EN
    logic [31:0] idle_cnt_q;

    assign stuck_hit = (idle_cnt_q == STUCK_CYCLES - 32'd1);

    // Count idle cycles with keys held; any activity or an empty table restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) idle_cnt_q <= '0;
        else if (accept || clr_req || table_empty) idle_cnt_q <= '0;
        else idle_cnt_q <= idle_cnt_q + 32'd1;
    end
`else
    logic unused_stuck;
    assign stuck_hit    = 1'b0;
    assign unused_stuck = ^{STUCK_CYCLES, table_empty};
`endif

    // Next-state, table commands and overflow update; a clear overrides all.
    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        tbl_wr  = 1'b0;
        tbl_rm  = 1'b0;
        case (state_q)
            IDLE:  if (accept) state_d = SCAN;
            SCAN:  if (scan_idx_q == LAST_IDX) state_d = APPLY;
            APPLY: begin
                state_d = IDLE;
                if (!is_reserved(code_q)) begin
                    if (make_q) begin
                        if (!match_found_q) begin
                            if (free_found_q)        tbl_wr = 1'b1;
                            else if (ovf_q != OVF_MAX) ovf_d = ovf_q + 4'd1;
                        end
                    end else begin
                        if (match_found_q)   tbl_rm = 1'b1;
                        else if (ovf_q != 0) ovf_d  = ovf_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr_req) begin
            state_d = IDLE;
            ovf_d   = '0;
            tbl_wr  = 1'b0;
            tbl_rm  = 1'b0;
        end
    end

    // Control state and overflow count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    // Latch the accepted event, then walk the slots recording match and first free slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q        <= '0;
            make_q        <= 1'b0;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
        end else if (accept) begin
            code_q        <= ev_code;
            make_q        <= ev_make;
            scan_idx_q    <= '0;
            match_found_q <= 1'b0;
            free_found_q  <= 1'b0;
        end else if (state_q == SCAN && !clr_req) begin
            if (scan_idx_q != LAST_IDX) scan_idx_q <= scan_idx_q + 1'b1;
            if (!match_found_q && rd_code == code_q) begin
                match_found_q <= 1'b1;
                match_idx_q   <= scan_idx_q;
            end
            if (!free_found_q && rd_code == CODE_W'(KEY_NONE)) begin
                free_found_q <= 1'b1;
                free_idx_q   <= scan_idx_q;
            end
        end
    end

    // While overflowed every slot reports ErrorRollOver; the table itself is kept.
    assign pub = (ovf_q != 0) ? {NUM_SLOTS{CODE_W'(KEY_ROLLOVER)}} : table_flat;

    // Remember the last published report so a change can be flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_pub_q <= '0;
        else       prev_pub_q <= pub;
    end

    assign keycode      = pub;
    assign report_valid = (pub != prev_pub_q);
    assign rollover     = (ovf_q != 0);

endmodule

// File: tb/tb_key_report_builder.sv
// Self-checking bench for key_report_builder: directed scenarios with literal
// expectations plus a randomized phase against a queue-based reference model.
module tb_key_report_builder;

    localparam int NS = 6;
`ifdef KEY_REPORT_BUILDER_STUCK_CLEAR_EN
    localparam int STUCK = 20;
`endif

    logic        clk, reset, ev_valid, ev_ready, ev_make, clear_all, report_valid, rollover;
    logic [7:0]  ev_code;
    logic [47:0] keycode;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    key_report_builder #(.NUM_SLOTS(NS), .CODE_W(8), .STUCK_CYCLES(20)) dut (
        .clk         (clk),
        .reset       (reset),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_code     (ev_code),
        .ev_make     (ev_make),
        .clear_all   (clear_all),
        .keycode     (keycode),
        .report_valid(report_valid),
        .rollover    (rollover)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time %0t reached without finishing", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  held[$];
    int          ovf_m  = 0;
    int          busy   = 0;
    int          stk    = 0;
    logic [7:0]  lc;
    logic        lm;
    logic [47:0] exp_pub = '0;
    logic        exp_rv  = 1'b0;

    function automatic logic [47:0] model_pub();
        logic [47:0] r;
        if (ovf_m > 0) return {6{8'h01}};
        r = '0;
        foreach (held[i]) r[i*8 +: 8] = held[i];
        return r;
    endfunction

    function automatic void apply_model();
        int idx;
        if (lc <= 8'h03) return;
        idx = -1;
        foreach (held[i]) if (held[i] == lc) idx = i;
        if (lm) begin
            if (idx < 0) begin
                if (held.size() < NS) held.push_back(lc);
                else if (ovf_m < 15) ovf_m++;
            end
        end else begin
            if (idx >= 0) held.delete(idx);
            else if (ovf_m > 0) ovf_m--;
        end
    endfunction

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        logic        clear_eff, exp_ready, accepted;
        logic [47:0] newp;
        if (reset) begin
            held.delete();
            ovf_m = 0; busy = 0; stk = 0;
            exp_pub = '0; exp_rv = 1'b0;
            chk("reset_keycode", keycode, 48'h0);
            chk("reset_report_valid", report_valid, 0);
            chk("reset_rollover", rollover, 0);
        end else begin
            clear_eff = clear_all;
`ifdef KEY_REPORT_BUILDER_STUCK_CLEAR_EN
            if (stk == STUCK - 1) clear_eff = 1'b1;
`endif
            exp_ready = (busy == 0) && !clear_eff;
            chk("model_keycode", keycode, exp_pub);
            chk("model_report_valid", report_valid, exp_rv);
            chk("model_rollover", rollover, ovf_m > 0);
            chk("model_ev_ready", ev_ready, exp_ready);
            if (report_valid) pulses++;
            accepted = exp_ready && ev_valid;
`ifdef KEY_REPORT_BUILDER_STUCK_CLEAR_EN
            if (accepted || clear_eff || held.size() == 0) stk = 0;
            else stk++;
`endif
            if (clear_eff) begin
                held.delete();
                ovf_m = 0;
                busy  = 0;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) apply_model();
            end else if (accepted) begin
                lc   = ev_code;
                lm   = ev_make;
                busy = NS + 1;
            end
            newp    = model_pub();
            exp_rv  = (newp != exp_pub);
            exp_pub = newp;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] c, input logic m);
        int n;
        @(posedge clk); #1;
        ev_valid = 1'b1; ev_code = c; ev_make = m;
        n = 0;
        while (ev_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready_wait", n < 20, 1);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        repeat (NS + 2) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(posedge clk); #1 clear_all = 1'b1;
        @(posedge clk); #1 clear_all = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        reset = 1'b1; ev_valid = 1'b0; ev_code = '0; ev_make = 1'b0; clear_all = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_keycode", keycode, 48'h0);
        chk("rst_ready", ev_ready, 1);
        reset = 1'b0;

        // Enter press: ready low for the scan/apply window, report at T+8.
        @(posedge clk); #1;
        ev_valid = 1'b1; ev_code = 8'h28; ev_make = 1'b1;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("busy_ready_low", ev_ready, 0);
            if (k == 7) chk("before_apply_keycode", keycode, 48'h0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("enter_keycode", keycode, 48'h000000000028);
        chk("enter_pulse", report_valid, 1);
        do_clear();

        // Two presses, a duplicate, then a release: three report changes.
        p0 = pulses;
        send(8'h05, 1'b1);
        send(8'h34, 1'b1);
        chk("two_press", keycode, 48'h3405);
        send(8'h05, 1'b1);
        send(8'h05, 1'b0);
        chk("after_release", keycode, 48'h34);
        repeat (2) @(posedge clk);
        chk("pulse_count", pulses - p0, 3);
        do_clear();

        // Fill all six slots, overflow, recover.
        for (int k = 4; k <= 9; k++) send(8'(k), 1'b1);
        chk("full_table", keycode, 48'h090807060504);
        send(8'h0A, 1'b1);
        chk("overflow_mask", keycode, 48'h010101010101);
        chk("overflow_flag", rollover, 1);
        send(8'h0A, 1'b0);
        chk("overflow_restore", keycode, 48'h090807060504);
        chk("overflow_clear", rollover, 0);
        do_clear();

        // Release from the middle compacts the table.
        send(8'h04, 1'b1);
        send(8'h05, 1'b1);
        send(8'h06, 1'b1);
        send(8'h05, 1'b0);
        chk("compact", keycode, 48'h0604);

        // clear_all during SCAN with two keys held, then clear_all alongside ev_valid.
        @(posedge clk); #1;
        ev_valid = 1'b1; ev_code = 8'h07; ev_make = 1'b1;
        @(posedge clk); #1 ev_valid = 1'b0;
        @(posedge clk); #1 clear_all = 1'b1;
        @(posedge clk); #1 clear_all = 1'b0;
        #1;
        chk("clear_keycode", keycode, 48'h0);
        chk("clear_pulse", report_valid, 1);
        chk("clear_idle_ready", ev_ready, 1);
        @(posedge clk); #1;
        clear_all = 1'b1; ev_valid = 1'b1; ev_code = 8'h11; ev_make = 1'b1;
        #1;
        chk("clear_blocks_ready", ev_ready, 0);
        @(posedge clk); #1;
        clear_all = 1'b0; ev_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("clear_no_accept", keycode, 48'h0);

        // Asynchronous reset in the APPLY cycle.
        send(8'h2B, 1'b1);
        @(posedge clk); #1;
        ev_valid = 1'b1; ev_code = 8'h2C; ev_make = 1'b1;
        @(posedge clk); #1 ev_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_keycode", keycode, 48'h2B);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_keycode", keycode, 48'h0);
        chk("async_reset_pulse", report_valid, 0);
        chk("async_reset_rollover", rollover, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("reset_drops_event", keycode, 48'h0);

        // Randomized traffic: press-heavy first half, release-heavy second half.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            ev_valid  = ($urandom_range(0, 9) < 7);
            ev_code   = 8'($urandom_range(0, 12));
            ev_make   = (c < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 4);
            clear_all = ($urandom_range(0, 99) < 2);
        end
        @(posedge clk); #1;
        ev_valid = 1'b0; clear_all = 1'b0;
        repeat (12) @(posedge clk);

`ifdef KEY_REPORT_BUILDER_STUCK_CLEAR_EN
        do_clear();
        send(8'h2D, 1'b1);
        chk("stuck_held", keycode, 48'h2D);
        repeat (30) @(posedge clk);
        #1;
        chk("stuck_autoclear", keycode, 48'h0);
`endif

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
